// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, default widths and FSM state type shared by the ALU arbiter slice
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W = 4;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational add/increment/negate/subtract; unknown opcodes yield zero, results wrap
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  // opcode decode into the wrapped arithmetic result
  always_comb
    y = op == OP_W'(OP_ADD) ? a + b :
        op == OP_W'(OP_INC) ? a + DATA_W'(1) :
        op == OP_W'(OP_NEG) ? DATA_W'(0) - a :
        op == OP_W'(OP_SUB) ? a - b : '0;
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer moves only when a grant is accepted
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last;
  // last granted requester; reset value 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (accept) last <= grant[1];
  assign grant = valid == 2'b11 ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through round-robin arbitration; ALU_ARBITER_ERR_EN enables illegal-opcode reporting
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_z,
  output logic              rsp_n,
  output logic              rsp_err
);
  state_t state, state_nx;
  logic [1:0] grant;
  logic accept, id_r;
  logic [OP_W-1:0] op_r;
  logic [DATA_W-1:0] a_r, b_r, y;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .valid(req_valid), .accept(accept), .grant(grant));
  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (.op(op_r), .a(a_r), .b(b_r), .y(y));
  assign req_ready = state == IDLE && !rst ? grant : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign rsp_valid = state == HOLD;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // IDLE waits for an accept, EXEC lasts one cycle, HOLD waits for the consumer
  always_comb
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? HOLD :
               state == HOLD && !rsp_ready ? HOLD : IDLE;
  // capture the granted request, then latch the ALU result into the response registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      id_r <= 1'b0;
      rsp_out <= '0;
      rsp_z <= 1'b0;
      rsp_n <= 1'b0;
      rsp_id <= 1'b0;
    end else if (accept) begin
      op_r <= req_ready[1] ? req_op1 : req_op0;
      a_r <= req_ready[1] ? req_a1 : req_a0;
      b_r <= req_ready[1] ? req_b1 : req_b0;
      id_r <= req_ready[1];
    end else if (state == EXEC) begin
      rsp_out <= y;
      rsp_z <= y == '0;
      rsp_n <= y[DATA_W-1];
      rsp_id <= id_r;
    end
`ifdef ALU_ARBITER_ERR_EN
  logic err_r;
  // flag opcodes outside the defined ADD..SUB range
  always_ff @(posedge clk or posedge rst)
    if (rst) err_r <= 1'b0;
    else if (state == EXEC) err_r <= op_r < OP_W'(OP_ADD) || op_r > OP_W'(OP_SUB);
  assign rsp_err = err_r;
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter (grant order, results, flags, latency, hold and reset behaviour)
module tb_alu_arbiter;
`ifdef ALU_ARBITER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef struct {
    logic id;
    logic [31:0] out;
    logic z, n, err;
  } exp_t;
  logic clk = 0, rst = 0, rsp_ready = 1;
  logic [1:0] req_valid = 0, req_ready;
  logic [3:0] req_op0 = 0, req_op1 = 0;
  logic [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
  logic rsp_valid, rsp_id, rsp_z, rsp_n, rsp_err;
  logic [31:0] rsp_out, save;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, resp_cnt = 0, n0 = 0;
  logic last_m = 1, prev_valid = 0, pick;
  exp_t e;
  exp_t q[$];

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a + 32'd1;
      4'b0110: return 32'd0 - a;
      4'b0111: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_m = 1'b1;
      prev_valid = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        pick = (req_valid[0] && (!req_valid[1] || last_m)) ? 1'b0 : 1'b1;
        chk("grant", {30'd0, req_ready}, pick ? 32'd2 : 32'd1);
        e.id = pick;
        e.out = pick ? f_alu(req_op1, req_a1, req_b1) : f_alu(req_op0, req_a0, req_b0);
        e.z = e.out == 0;
        e.n = e.out[31];
        e.err = ERR_EN && !((pick ? req_op1 : req_op0) inside {[4'd4:4'd7]});
        q.push_back(e);
        last_m = pick;
        acc_cyc = cyc;
      end
      if (rsp_valid && !prev_valid) chk("latency", cyc - acc_cyc, 2);
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_out", rsp_out, e.out);
          chk("rsp_z", {31'd0, rsp_z}, {31'd0, e.z});
          chk("rsp_n", {31'd0, rsp_n}, {31'd0, e.n});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          resp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() != 0 || rsp_valid); i++) @(posedge clk);
    #1 chk("drain", q.size(), 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    req_valid = 2'b11;
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_ready", {30'd0, req_ready}, 0);
    chk("rst_out", rsp_out, 0);
    chk("rst_flags", {28'd0, rsp_z, rsp_n, rsp_id, rsp_err}, 0);
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(0, 4'b0100, 5, 7);
    send(1, 4'b0111, 3, 5);
    send(1, 4'b0110, 0, 0);
    send(0, 4'b0101, 32'hFFFF_FFFF, 0);
    send(1, 4'b0000, 9, 9);
    send(0, 4'b1111, 1, 2);
    send(1, 4'b0100, 32'h7FFF_FFFF, 1);
    drain();
    pulse_rst();
    req_op0 = 4'b0100; req_a0 = 1; req_b0 = 2;
    req_op1 = 4'b0111; req_a1 = 10; req_b1 = 3;
    req_valid = 2'b11;
    n0 = resp_cnt;
    for (int i = 0; i < 40 && resp_cnt < n0 + 4; i++) @(posedge clk);
    #1 req_valid = 0;
    chk("alt_count", {31'd0, resp_cnt >= n0 + 4}, 1);
    drain();
    rsp_ready = 0;
    send(0, 4'b0111, 100, 1);
    @(posedge clk);
    #1 save = rsp_out;
    chk("hold_val", save, 99);
    req_valid = 2'b11;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, rsp_valid}, 1);
      chk("hold_out", rsp_out, save);
      chk("hold_flags", {29'd0, rsp_z, rsp_n, rsp_id}, 0);
      chk("hold_ready", {30'd0, req_ready}, 0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
    #1 chk("release_idle", {31'd0, rsp_valid}, 0);
    req_valid = 2'b11;
    for (int i = 0; i < 10 && req_ready == 0; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 0;
    rst = 1;
    #1 chk("rst_exec_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("no_rsp_exec", {31'd0, rsp_valid}, 0);
    end
    rsp_ready = 0;
    send(1, 4'b0100, 1, 1);
    @(posedge clk);
    #1 chk("pre_rst_hold", {31'd0, rsp_valid}, 1);
    rst = 1;
    #1 chk("rst_hold_valid", {31'd0, rsp_valid}, 0);
    chk("rst_hold_out", rsp_out, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    rsp_ready = 1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("no_rsp_hold", {31'd0, rsp_valid}, 0);
    end
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", {30'd0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
